// File: rtl/sfu_issue_scheduler.sv
// Round-robin issue scheduler sharing one SFU between NREQ requesters; one op in flight,
// done pulses LAT cycles after gnt (+1 per stalled WAIT cycle); stall freezes ISSUE and WAIT only.
module sfu_issue_scheduler #(
  parameter int NREQ      = 4,
  parameter int TAGW      = 4,
  parameter int LAT_LONG  = 8,
  parameter int LAT_SHORT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [3*NREQ-1:0]      req_selop,
  input  logic [TAGW*NREQ-1:0]   req_tag,
  input  logic                   stall,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        err,
  output logic                   sfu_valid,
  output logic [2:0]             sfu_selop,
  output logic [TAGW-1:0]        sfu_tag,
  output logic [NREQ-1:0]        done,
  output logic [TAGW-1:0]        done_tag,
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, REJ} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d, rr_next;
  logic [PW-1:0]   w_q, win;
  logic            win_vld;
  logic [2:0]      selop_q, win_selop;
  logic [TAGW-1:0] tag_q, win_tag, done_tag_q;
  logic [7:0]      cnt_q, cnt_d, lat_m2;
  logic [NREQ-1:0] w_onehot;

  // First asserted request at or after rr_q, wrapping around.
  always_comb begin : arb
    int idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && req[PW'(idx)]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  assign win_selop = req_selop[3*int'(win) +: 3];
  assign win_tag   = req_tag[TAGW*int'(win) +: TAGW];
  assign w_onehot  = NREQ'(1) << w_q;
  assign rr_next   = (w_q == PW'(NREQ-1)) ? '0 : w_q + PW'(1);
  assign lat_m2    = (selop_q <= 3'd1) ? 8'(LAT_LONG - 2) : 8'(LAT_SHORT - 2);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    gnt       = '0;
    err       = '0;
    done      = '0;
    sfu_valid = 1'b0;
    sfu_selop = 3'd0;
    sfu_tag   = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) state_d = (win_selop <= 3'd5) ? ISSUE : REJ;
      end
      ISSUE: begin
        sfu_valid = 1'b1;
        sfu_selop = selop_q;
        sfu_tag   = tag_q;
        if (!stall) begin
          gnt     = w_onehot;
          cnt_d   = lat_m2;
          rr_d    = rr_next;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!stall) begin
          if (cnt_q == 8'd0) state_d = RESP;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      RESP: begin
        done    = w_onehot;
        state_d = IDLE;
      end
      REJ: begin
        err     = w_onehot;
        rr_d    = rr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      cnt_q      <= 8'd0;
      w_q        <= '0;
      selop_q    <= 3'd0;
      tag_q      <= '0;
      done_tag_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      // Operand capture only at arbitration so in-flight ops ignore later req_* changes.
      if (state_q == IDLE && win_vld) begin
        w_q     <= win;
        selop_q <= win_selop;
        tag_q   <= win_tag;
      end
      if (state_q == WAIT && state_d == RESP) done_tag_q <= tag_q;
    end
  end

  assign done_tag = done_tag_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sfu_issue_scheduler.sv
// Randomized scoreboard bench for sfu_issue_scheduler: a service-order model feeds an
// expectation queue that a negedge monitor checks against gnt/err/sfu/done activity.
module tb_sfu_issue_scheduler;
  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int LATL = 8;
  localparam int LATS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [3*NREQ-1:0]    req_selop;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 stall;
  logic [NREQ-1:0]      gnt, err, done;
  logic                 sfu_valid, busy;
  logic [2:0]           sfu_selop;
  logic [TAGW-1:0]      sfu_tag, done_tag;

  always #5 clk = ~clk;

  sfu_issue_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .LAT_LONG(LATL), .LAT_SHORT(LATS)) dut (
    .clk(clk), .rst(rst), .req(req), .req_selop(req_selop), .req_tag(req_tag),
    .stall(stall), .gnt(gnt), .err(err), .sfu_valid(sfu_valid), .sfu_selop(sfu_selop),
    .sfu_tag(sfu_tag), .done(done), .done_tag(done_tag), .busy(busy)
  );

  typedef struct {
    int              idx;
    logic [2:0]      selop;
    logic [TAGW-1:0] tag;
    bit              is_err;
  } exp_t;

  exp_t            q[$];
  exp_t            cur;
  int              n_cmp = 0;
  int              n_bad = 0;
  int              rr_m = 0;
  bit              inflight = 0;
  int              wcnt = 0;
  logic [TAGW-1:0] last_tag = '0;
  bit              stall_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [2:0] s);
    return (s <= 3'd1) ? LATL : LATS;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sfu_valid", 32'(sfu_valid), 0);
    chk("rst_sfu_selop", 32'(sfu_selop), 0);
    chk("rst_sfu_tag", 32'(sfu_tag), 0);
    chk("rst_done_tag", 32'(done_tag), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Stall changes just after the rising edge so it is stable for the monitor at negedge.
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: pops one expectation per gnt/err and tracks the in-flight op to its done.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      inflight = 0;
      last_tag = '0;
    end else begin
      if (sfu_valid) begin
        if (q.size() == 0) chk("sfu_valid_unexpected", 1, 0);
        else begin
          chk("sfu_valid_for_legal", 32'(q[0].is_err), 0);
          chk("sfu_selop", 32'(sfu_selop), 32'(q[0].selop));
          chk("sfu_tag", 32'(sfu_tag), 32'(q[0].tag));
        end
      end
      if (gnt != 0 || err != 0) begin
        if (q.size() == 0) chk("grant_unexpected", 32'({gnt, err}), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("gnt_vec", 32'(gnt), e.is_err ? 0 : (32'd1 << e.idx));
          chk("err_vec", 32'(err), e.is_err ? (32'd1 << e.idx) : 0);
          if (err != 0) chk("err_no_sfu_valid", 32'(sfu_valid), 0);
          if (gnt != 0) begin
            chk("gnt_not_stalled", 32'(stall), 0);
            inflight = 1;
            cur      = e;
            wcnt     = 0;
          end
        end
      end else if (inflight) begin
        if (done != 0) begin
          chk("done_vec", 32'(done), 32'd1 << cur.idx);
          chk("done_tag", 32'(done_tag), 32'(cur.tag));
          chk("done_latency", wcnt, lat_of(cur.selop) - 1);
          inflight = 0;
          last_tag = cur.tag;
        end else if (!stall) begin
          wcnt++;
        end
      end else if (done != 0) begin
        chk("done_unexpected", 32'(done), 0);
      end
      if (done == 0) chk("done_tag_hold", 32'(done_tag), 32'(last_tag));
    end
  end

  // Present a set of simultaneous requests; the model derives the service order from rr_m.
  task automatic run_batch(input logic [NREQ-1:0] mask, input bit allow_illegal);
    logic [NREQ-1:0] pending;
    int              w;
    int              cycles;
    exp_t            e;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        logic [2:0] s;
        s = (allow_illegal && $urandom_range(0, 4) == 0) ? 3'($urandom_range(6, 7))
                                                         : 3'($urandom_range(0, 5));
        req_selop[3*i +: 3]      = s;
        req_tag[TAGW*i +: TAGW]  = TAGW'($urandom);
      end
    end
    pending = mask;
    while (pending != 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (rr_m + k) % NREQ;
        if (w < 0 && pending[c]) w = c;
      end
      e.idx    = w;
      e.selop  = req_selop[3*w +: 3];
      e.tag    = req_tag[TAGW*w +: TAGW];
      e.is_err = (e.selop > 3'd5);
      q.push_back(e);
      pending[w] = 1'b0;
      rr_m = (w + 1) % NREQ;
    end
    req    = mask;
    cycles = 0;
    while ((req != 0 || q.size() != 0 || inflight) && cycles < 3000) begin
      @(negedge clk);
      req = req & ~(gnt | err);
      cycles++;
    end
    if (cycles >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL batch_timeout: got %0d pending, required 0", q.size());
    end
  endtask

  task automatic reset_mid_wait();
    exp_t e;
    int   cycles;
    stall_en = 0;
    @(negedge clk);
    req_selop[6 +: 3] = 3'b000;
    req_tag[8 +: 4]   = 4'hA;
    e.idx = 2; e.selop = 3'b000; e.tag = 4'hA; e.is_err = 0;
    q.push_back(e);
    rr_m = 3;
    req  = 4'b0100;
    cycles = 0;
    while (!gnt[2] && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    chk("rst_test_gnt_seen", 32'(gnt[2]), 1);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_reset_outputs();
    rr_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (LATL + 4) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    req_selop = '0;
    req_tag   = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_batch(4'b0001, 0);
    run_batch(4'b1111, 0);
    stall_en = 1;
    run_batch(4'b1111, 1);
    run_batch(4'b1010, 1);
    reset_mid_wait();
    stall_en = 1;
    run_batch(4'b1111, 1);
    for (int b = 0; b < 40; b++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      stall_en = ($urandom_range(0, 2) != 0);
      run_batch(m, 1);
    end
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
